// File: rtl/alu_stage.sv
// Execute stage of the SimpleRISC pipeline.
// Single-cycle ALU ops resolve combinationally; signed div/mod runs on a
// 32-step restoring divider that stalls the front of the pipeline while busy.
// The E/GT compare flags are held in registers.
module alu_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op1_ALU,
    input  logic [31:0] op2_ALU,
    input  logic [12:0] aluSignals_ALU,
    input  logic        valid_ALU,
    output logic [31:0] aluResult,
    output logic        resultValid,
    output logic        stall,
    output logic        flagE,
    output logic        flagGT
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] quo;       // dividend shifts out, quotient shifts in
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic        is_mod;

    logic [12:0] sel;
    logic        op_add, op_sub, op_mul, op_div, op_mod, op_cmp;
    logic        op_and, op_or, op_not, op_mov, op_lsl, op_lsr, op_asr;
    logic        special;
    logic        start;
    logic [31:0] abs1, abs2;
    logic [31:0] single;
    logic [32:0] trial;
    logic [32:0] diff;
    logic [31:0] q_fix, r_fix;
    logic [4:0]  shamt;

    // Isolate the lowest set select bit and derive divider control terms
    always_comb begin
        sel     = aluSignals_ALU & (~aluSignals_ALU + 13'd1);
        op_add  = sel[0];
        op_sub  = sel[1];
        op_mul  = sel[2];
        op_div  = sel[3];
        op_mod  = sel[4];
        op_cmp  = sel[5];
        op_and  = sel[6];
        op_or   = sel[7];
        op_not  = sel[8];
        op_mov  = sel[9];
        op_lsl  = sel[10];
        op_lsr  = sel[11];
        op_asr  = sel[12];
        special = (op2_ALU == '0) || ((op1_ALU == 32'h8000_0000) && (op2_ALU == '1));
        start   = valid_ALU && (op_div || op_mod) && !special;
        abs1    = op1_ALU[31] ? (~op1_ALU + 32'd1) : op1_ALU;
        abs2    = op2_ALU[31] ? (~op2_ALU + 32'd1) : op2_ALU;
        shamt   = op2_ALU[4:0];
    end

    // Single-cycle result, including the divide special cases
    always_comb begin
        single = '0;
        if (op_add)      single = op1_ALU + op2_ALU;
        else if (op_sub) single = op1_ALU - op2_ALU;
        else if (op_mul) single = op1_ALU * op2_ALU;
        else if (op_div) single = (op2_ALU == '0) ? '1 : 32'h8000_0000;
        else if (op_mod) single = (op2_ALU == '0) ? op1_ALU : '0;
        else if (op_cmp) single = '0;
        else if (op_and) single = op1_ALU & op2_ALU;
        else if (op_or)  single = op1_ALU | op2_ALU;
        else if (op_not) single = ~op2_ALU;
        else if (op_mov) single = op2_ALU;
        else if (op_lsl) single = op1_ALU << shamt;
        else if (op_lsr) single = op1_ALU >> shamt;
        else if (op_asr) single = $unsigned($signed(op1_ALU) >>> shamt);
    end

    // Restoring step, sign fix-up and output muxing
    always_comb begin
        trial       = {rem, quo[31]};
        diff        = trial - {1'b0, dvs};
        q_fix       = neg_q ? (~quo + 32'd1) : quo;
        r_fix       = neg_r ? (~rem + 32'd1) : rem;
        stall       = !reset && (((state == IDLE) && start) || (state == BUSY));
        resultValid = valid_ALU && !stall && !reset;
        aluResult   = '0;
        if (reset)              aluResult = '0;
        else if (state == DONE) aluResult = is_mod ? r_fix : q_fix;
        else if (state == IDLE) aluResult = single;
    end

    // Divider FSM and compare flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_mod <= 1'b0;
            flagE  <= 1'b0;
            flagGT <= 1'b0;
        end else begin
            if (valid_ALU && !stall && op_cmp) begin
                flagE  <= (op1_ALU == op2_ALU);
                flagGT <= ($signed(op1_ALU) > $signed(op2_ALU));
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        quo    <= abs1;
                        rem    <= '0;
                        dvs    <= abs2;
                        neg_q  <= op1_ALU[31] ^ op2_ALU[31];
                        neg_r  <= op1_ALU[31];
                        is_mod <= op_mod;
                    end
                end
                BUSY: begin
                    quo <= {quo[30:0], ~diff[32]};
                    rem <= diff[32] ? trial[31:0] : diff[31:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed vectors with literal
// expectations, plus a cycle-by-cycle comparison against a behavioural model.
module tb_alu_stage;

    logic        clk;
    logic        reset;
    logic [31:0] op1_ALU;
    logic [31:0] op2_ALU;
    logic [12:0] aluSignals_ALU;
    logic        valid_ALU;
    logic [31:0] aluResult;
    logic        resultValid;
    logic        stall;
    logic        flagE;
    logic        flagGT;

    int checks = 0;
    int errors = 0;

    localparam logic [12:0] S_ADD = 13'h0001, S_SUB = 13'h0002, S_MUL = 13'h0004,
                            S_DIV = 13'h0008, S_MOD = 13'h0010, S_CMP = 13'h0020,
                            S_AND = 13'h0040, S_OR  = 13'h0080, S_NOT = 13'h0100,
                            S_MOV = 13'h0200, S_LSL = 13'h0400, S_LSR = 13'h0800,
                            S_ASR = 13'h1000;

    alu_stage dut (
        .clk            (clk),
        .reset          (reset),
        .op1_ALU        (op1_ALU),
        .op2_ALU        (op2_ALU),
        .aluSignals_ALU (aluSignals_ALU),
        .valid_ALU      (valid_ALU),
        .aluResult      (aluResult),
        .resultValid    (resultValid),
        .stall          (stall),
        .flagE          (flagE),
        .flagGT         (flagGT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int op_index(input logic [12:0] s);
        for (int i = 0; i < 13; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_res(input logic [12:0] s, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (op_index(s))
            0:  return a + b;
            1:  return a - b;
            2:  return a * b;
            3:  begin
                    if (b == 0) return 32'hFFFF_FFFF;
                    q = la / lb;
                    return q[31:0];
                end
            4:  begin
                    if (b == 0) return a;
                    q = la % lb;
                    return q[31:0];
                end
            6:  return a & b;
            7:  return a | b;
            8:  return ~b;
            9:  return b;
            10: return a << b[4:0];
            11: return a >> b[4:0];
            12: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_long(input logic [12:0] s, input logic [31:0] a, input logic [31:0] b);
        int k;
        k = op_index(s);
        if (k != 3 && k != 4) return 0;
        if (b == 0) return 0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 1;
    endfunction

    // Compare process: inputs are stable across the negedge and are the
    // values the next posedge will sample.
    initial begin : compare
        int          since_issue;
        logic [31:0] div_res;
        logic        mE, mGT;
        since_issue = 0;
        div_res     = '0;
        mE          = 1'b0;
        mGT         = 1'b0;
        forever begin
            @(negedge clk);
            chk("m_flagE", {31'b0, flagE}, {31'b0, mE});
            chk("m_flagGT", {31'b0, flagGT}, {31'b0, mGT});
            if (reset) begin
                chk("m_rst_stall", {31'b0, stall}, 32'h0);
                chk("m_rst_rv", {31'b0, resultValid}, 32'h0);
                chk("m_rst_res", aluResult, 32'h0);
                mE = 1'b0; mGT = 1'b0; since_issue = 0;
            end else if (since_issue >= 1 && since_issue <= 32) begin
                chk("m_busy_stall", {31'b0, stall}, 32'h1);
                chk("m_busy_rv", {31'b0, resultValid}, 32'h0);
                since_issue++;
            end else if (since_issue == 33) begin
                chk("m_done_stall", {31'b0, stall}, 32'h0);
                chk("m_done_rv", {31'b0, resultValid}, {31'b0, valid_ALU});
                if (valid_ALU) chk("m_done_res", aluResult, div_res);
                since_issue = 0;
            end else if (valid_ALU && model_long(aluSignals_ALU, op1_ALU, op2_ALU)) begin
                chk("m_issue_stall", {31'b0, stall}, 32'h1);
                chk("m_issue_rv", {31'b0, resultValid}, 32'h0);
                div_res     = model_res(aluSignals_ALU, op1_ALU, op2_ALU);
                since_issue = 1;
            end else begin
                chk("m_stall", {31'b0, stall}, 32'h0);
                chk("m_rv", {31'b0, resultValid}, {31'b0, valid_ALU});
                if (valid_ALU) begin
                    chk("m_res", aluResult, model_res(aluSignals_ALU, op1_ALU, op2_ALU));
                    if (op_index(aluSignals_ALU) == 5) begin
                        mE  = (op1_ALU == op2_ALU);
                        mGT = ($signed(op1_ALU) > $signed(op2_ALU));
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic apply(input logic [12:0] s, input logic [31:0] a, input logic [31:0] b, input logic v);
        @(posedge clk);
        #1;
        aluSignals_ALU = s;
        op1_ALU        = a;
        op2_ALU        = b;
        valid_ALU      = v;
    endtask

    task automatic one(input string name, input logic [12:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        apply(s, a, b, 1'b1);
        #3;
        chk(name, aluResult, exp);
        chk({name, "_rv"}, {31'b0, resultValid}, 32'h1);
        chk({name, "_stall"}, {31'b0, stall}, 32'h0);
    endtask

    task automatic do_cmp(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic e, input logic gt);
        one(name, S_CMP, a, b, 32'h0);
        apply(S_ADD, 32'h0, 32'h0, 1'b0);
        #3;
        chk({name, "_E"}, {31'b0, flagE}, {31'b0, e});
        chk({name, "_GT"}, {31'b0, flagGT}, {31'b0, gt});
    endtask

    // Hold the instruction while stalled; check the result in the first
    // non-stalled cycle and the number of stalled cycles before it.
    task automatic run_div(input string name, input logic [12:0] s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
        int n;
        n = 0;
        apply(s, a, b, 1'b1);
        for (int i = 0; i < 40; i++) begin
            #3;
            if (!stall) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk({name, "_stalls"}, n, exp_stalls);
        chk(name, aluResult, exp);
        chk({name, "_rv"}, {31'b0, resultValid}, 32'h1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset          = 1'b1;
        op1_ALU        = '0;
        op2_ALU        = '0;
        aluSignals_ALU = '0;
        valid_ALU      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        chk("rst_flagE", {31'b0, flagE}, 32'h0);
        chk("rst_flagGT", {31'b0, flagGT}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);

        one("add_wrap", S_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        one("sub_neg",  S_SUB, 32'h5, 32'h7, 32'hFFFF_FFFE);
        one("mul_neg",  S_MUL, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD);
        one("asr",      S_ASR, 32'h8000_0000, 32'h21, 32'hC000_0000);
        one("lsr",      S_LSR, 32'h8000_0000, 32'h21, 32'h4000_0000);
        one("lsl",      S_LSL, 32'h1, 32'h24, 32'h10);
        one("and",      S_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        one("or",       S_OR,  32'hF0F0_F0F0, 32'h0F00_000F, 32'hFFF0_F0FF);
        one("not",      S_NOT, 32'h1234_5678, 32'h0000_000F, 32'hFFFF_FFF0);
        one("mov",      S_MOV, 32'h1234_5678, 32'hCAFE_F00D, 32'hCAFE_F00D);
        one("prio_add", 13'h0003, 32'h5, 32'h7, 32'hC);
        one("noop",     13'h0000, 32'h5, 32'h7, 32'h0);

        apply(S_ADD, 32'h1, 32'h1, 1'b0);
        #3;
        chk("invalid_rv", {31'b0, resultValid}, 32'h0);

        do_cmp("cmp_gt",  32'h5, 32'hFFFF_FFFD, 1'b0, 1'b1);
        do_cmp("cmp_neg", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);

        run_div("div_m7_2", S_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
        one("add_after_div", S_ADD, 32'h1, 32'h2, 32'h3);
        run_div("mod_m7_2", S_MOD, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
        do_cmp("cmp_eq", 32'h9, 32'h9, 1'b1, 1'b0);

        run_div("div_by0", S_DIV, 32'hA, 32'h0, 32'hFFFF_FFFF, 0);
        run_div("mod_by0", S_MOD, 32'hA, 32'h0, 32'hA, 0);
        run_div("div_ovf", S_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_div("mod_ovf", S_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
        run_div("div_100_m7", S_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        run_div("mod_m100_7", S_MOD, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);

        // reset during iteration 15 of 100/7; flagE is 1 from the last cmp
        apply(S_DIV, 32'd100, 32'd7, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        reset = 1'b1;
        #3;
        chk("midrst_stall", {31'b0, stall}, 32'h0);
        chk("midrst_rv", {31'b0, resultValid}, 32'h0);
        chk("midrst_res", aluResult, 32'h0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        valid_ALU = 1'b0;
        #3;
        chk("midrst_flagE", {31'b0, flagE}, 32'h0);
        chk("midrst_flagGT", {31'b0, flagGT}, 32'h0);
        repeat (40) @(posedge clk);
        run_div("div_100_7", S_DIV, 32'd100, 32'd7, 32'd14, 33);
        run_div("mod_100_7", S_MOD, 32'd100, 32'd7, 32'd2, 33);

        apply(S_ADD, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_stage.md
# alu_stage

Execute stage of the SimpleRISC pipeline. Consumes the registered operands and one-hot ALU control produced by the OF→ALU pipeline register. Computes the result for the next pipeline register and holds the compare flags E/GT. Single-cycle ops finish combinationally; signed div/mod runs on an iterative 32-step divider and stalls the front of the pipeline while busy.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- op1_ALU  in  32  operand 1 (rs1 value)
- op2_ALU  in  32  operand 2 (rs2 or immediate)
- aluSignals_ALU  in  13  one-hot op select, bits [0..12]: add, sub, mul, div, mod, cmp, and, or, not, mov, lsl, lsr, asr
- valid_ALU  in  1  instruction present in ALU stage
- aluResult  out  32  result to the ALU→MA pipeline register
- resultValid  out  1  aluResult is final this cycle
- stall  out  1  upstream registers (PC, IF/OF, OF/ALU) hold while 1
- flagE  out  1  registered equal flag
- flagGT  out  1  registered signed greater-than flag

## Operation
- Op select: lowest set bit wins if more than one bit is set. All-zero = no op: aluResult=0, resultValid=valid_ALU.
- add/sub: 32-bit two's complement, wrap, no carry out.
- mul: low 32 bits of signed product, single cycle.
- and/or: bitwise. not: ~op2. mov: op2.
- lsl/lsr/asr: shift op1 by op2[4:0]; op2[31:5] ignored.
- cmp: aluResult=0. At posedge with valid_ALU=1 and stall=0: flagE←(op1==op2), flagGT←($signed(op1)>$signed(op2)). Flags otherwise hold.
- div/mod: signed, quotient truncates toward zero, remainder takes the dividend's sign. Internally uses magnitudes plus a restoring divider (one quotient bit per cycle) with sign fix-up at the end.
- Special cases resolve in the issue cycle, with no FSM entry and stall=0:
  - op2=0: div→0xFFFFFFFF, mod→op1.
  - op1=0x80000000 with op2=0xFFFFFFFF: div→0x80000000, mod→0.
- FSM states IDLE, BUSY, DONE. Iteration counter is 5 bits.
  - IDLE→BUSY when valid_ALU & (div|mod) & not a special case. Capture magnitudes, signs and op type; counter←0.
  - BUSY: one iteration per cycle. Counter increments, wrapping 31→0. Go to DONE after the iteration with counter=31.
  - DONE→IDLE unconditionally. DONE never starts a new divide, even though the same instruction is still presented with valid_ALU=1.
- stall = (IDLE & start condition) | BUSY. It is combinational from the inputs in IDLE.
- resultValid = valid_ALU & ~stall & ~reset. In DONE, aluResult is the signed-corrected quotient or remainder.
- Inputs are ignored while BUSY. Upstream holding them stable is required, not checked.

## Timing
- Single-cycle ops: result and resultValid in the same cycle as valid_ALU (0-cycle latency). Flags visible the cycle after a cmp.
- Divide issued in cycle T:
  - stall=1 in T..T+32.
  - DONE in T+33, with stall=0, resultValid=1 and the result on aluResult.
  - The next instruction is accepted in T+34.
  - Total occupancy is 34 cycles.
- A cmp immediately after a divide updates the flags only in its own non-stalled cycle.
- Reset, including mid-divide:
  - Next state is IDLE; counter and divider registers clear.
  - flagE=flagGT=0.
  - During the reset cycle, stall=0, resultValid=0 and aluResult=0.
  - A partial divide is discarded and never reports.

## Test plan
- add 0x7FFFFFFF+1 → 0x80000000. sub 5−7 → 0xFFFFFFFE. mul 0xFFFFFFFF×3 → 0xFFFFFFFD. All with resultValid=1 and stall=0 in the same cycle.
- Shifts and flags:
  - asr 0x80000000 by op2=0x21 (amount 1) → 0xC0000000.
  - lsr same → 0x40000000.
  - cmp −1 vs 1 → flagE=0, flagGT=0 next cycle.
  - cmp 9 vs 9 → flagE=1, flagGT=0.
- div −7/2 held valid: stall=1 for exactly 33 cycles, DONE → aluResult=0xFFFFFFFD. mod −7/2 → 0xFFFFFFFF. A following add is accepted exactly one cycle after DONE.
- div 10/0 → 0xFFFFFFFF, mod 10/0 → 10. div 0x80000000/−1 → 0x80000000. All with no stall.
- Assert reset at iteration 15 of 100/7: stall drops in the reset cycle, flags are 0, no resultValid appears afterwards, and a fresh 100/7 returns 14 (mod → 2).
- aluSignals=0x0003 (add and sub both set): add is performed. aluSignals=0 → result 0.
